// File: rtl/systolic_matmul_core_pkg.sv
// Shared FSM state type and width helpers for the systolic matrix-multiply core.
package systolic_matmul_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED
    } state_e;

    function automatic int acc_width(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

    function automatic int row_w(input int n);
        return $clog2(2 * n);
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(3 * n);
    endfunction

endpackage

// File: rtl/systolic_matmul_core_pe.sv
// One output-stationary MAC cell: accumulates a*b, forwards a right and b down through one register each.
module systolic_matmul_core_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr_pipe,
    input  logic              clr_acc,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic                  sign_a;
    logic                  sign_b;
    logic [2*DATA_W-1:0]   prod;
    logic [ACC_W-1:0]      prod_ext;

    // The low 2*DATA_W bits of a product are the same for signed and unsigned
    // operands once the operands are extended correctly to 2*DATA_W.
    always_comb begin
        sign_a   = (SIGNED != 0) && a_in[DATA_W-1];
        sign_b   = (SIGNED != 0) && b_in[DATA_W-1];
        prod     = {{DATA_W{sign_a}}, a_in} * {{DATA_W{sign_b}}, b_in};
        prod_ext = {{(ACC_W-2*DATA_W){(SIGNED != 0) && prod[2*DATA_W-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr_pipe) begin
            a_out <= '0;
            b_out <= '0;
            if (clr_acc) begin
                acc <= '0;
            end
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_matmul_core.sv
// NxN output-stationary systolic multiply C = A*W with on-chip operand store and registered readback.
// state | meaning
// IDLE  | waiting for start; operand writes accepted
// CLEAR | one cycle: zero pipe regs, zero accumulators unless accumulating
// FEED  | skewed operand feed, t = 0..3N-2; busy drops on the final count
module systolic_matmul_core
    import systolic_matmul_core_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = acc_width(N, DATA_W),
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [row_w(N)-1:0]   reg_addr,
    input  logic [idx_w(N)-1:0]   idx,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  start,
    input  logic                  accum,
    input  logic [idx_w(N)-1:0]   rd_row,
    input  logic [idx_w(N)-1:0]   rd_col,
    output logic [ACC_W-1:0]      rd_data,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = idx_w(N);
    localparam int CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(3 * N - 2);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   t_cnt, t_nxt;
    logic               accum_q, accum_nxt;
    logic               done_nxt;
    logic               feeding, last_feed, wr_ok;
    logic               pe_en, clr_pipe, clr_acc;
    logic [CNT_W-1:0]   skew_k;

    logic [DATA_W-1:0]  store  [2*N][N];
    logic [DATA_W-1:0]  a_feed [N];
    logic [DATA_W-1:0]  b_feed [N];
    logic [DATA_W-1:0]  a_link [N][N];
    logic [DATA_W-1:0]  b_link [N][N];
    logic [ACC_W-1:0]   acc    [N][N];

    assign feeding   = (state == FEED);
    assign last_feed = feeding && (t_cnt == T_LAST);
    // The final feed cycle only pushes zeros, so the engine is free to accept
    // a write or a new start on the same edge that raises done.
    assign busy      = (state == CLEAR) || (feeding && !last_feed);
    assign wr_ok     = en && wr_en && !busy && (int'(reg_addr) < 2 * N) && (int'(idx) < N);
    assign pe_en     = en && feeding;
    assign clr_pipe  = en && (state == CLEAR);
    assign clr_acc   = clr_pipe && !accum_q;

    always_comb begin
        state_nxt = state;
        t_nxt     = t_cnt;
        accum_nxt = accum_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    accum_nxt = accum;
                end
            end
            CLEAR: begin
                state_nxt = FEED;
                t_nxt     = '0;
            end
            FEED: begin
                if (last_feed) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    if (start) begin
                        state_nxt = CLEAR;
                        accum_nxt = accum;
                    end
                end else begin
                    t_nxt = t_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            t_cnt   <= '0;
            accum_q <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            state   <= state_nxt;
            t_cnt   <= t_nxt;
            accum_q <= accum_nxt;
            done    <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 2 * N; r++) begin
                for (int c = 0; c < N; c++) begin
                    store[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            store[reg_addr][idx] <= data_in;
        end
    end

    // Row i / column i sees element t-i, giving the diagonal skew of the wavefront.
    always_comb begin
        skew_k = '0;
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            skew_k    = t_cnt - CNT_W'(i);
            if (feeding && (t_cnt >= CNT_W'(i)) && (skew_k < CNT_W'(N))) begin
                a_feed[i] = store[i][skew_k[IDX_W-1:0]];
                b_feed[i] = store[N+i][skew_k[IDX_W-1:0]];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_in_w;
            logic [DATA_W-1:0] b_in_w;
            if (j == 0) begin : g_a_edge
                assign a_in_w = a_feed[i];
            end else begin : g_a_link
                assign a_in_w = a_link[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in_w = b_feed[j];
            end else begin : g_b_link
                assign b_in_w = b_link[i-1][j];
            end
            systolic_matmul_core_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (pe_en),
                .clr_pipe (clr_pipe),
                .clr_acc  (clr_acc),
                .a_in     (a_in_w),
                .b_in     (b_in_w),
                .a_out    (a_link[i][j]),
                .b_out    (b_link[i][j]),
                .acc      (acc[i][j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (en) begin
            if ((int'(rd_row) < N) && (int'(rd_col) < N)) begin
                rd_data <= acc[rd_row][rd_col];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_core.sv
// Directed bench: 8x8 unsigned and 4x4 signed engines, results checked against a software model via a scoreboard queue.
module tb_systolic_matmul_core;

    localparam int AW8 = 35;
    localparam int AW4 = 18;
    localparam logic [63:0] MASK8 = (64'd1 << AW8) - 64'd1;
    localparam logic [63:0] MASK4 = (64'd1 << AW4) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           en, wr_en, start, accum, busy, done;
    logic [3:0]     reg_addr;
    logic [2:0]     idx, rd_row, rd_col;
    logic [15:0]    data_in;
    logic [AW8-1:0] rd_data;

    logic           en4, wr_en4, start4, accum4, busy4, done4;
    logic [2:0]     reg_addr4;
    logic [1:0]     idx4, rd_row4, rd_col4;
    logic [7:0]     data_in4;
    logic [AW4-1:0] rd_data4;

    systolic_matmul_core #(.N(8), .DATA_W(16), .SIGNED(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .reg_addr(reg_addr), .idx(idx),
        .data_in(data_in), .start(start), .accum(accum), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .busy(busy), .done(done)
    );

    systolic_matmul_core #(.N(4), .DATA_W(8), .SIGNED(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .wr_en(wr_en4), .reg_addr(reg_addr4), .idx(idx4),
        .data_in(data_in4), .start(start4), .accum(accum4), .rd_row(rd_row4), .rd_col(rd_col4),
        .rd_data(rd_data4), .busy(busy4), .done(done4)
    );

    int          a_m [8][8];
    int          w_m [8][8];
    longint      c_m [8][8];
    logic [63:0] sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr8(input int r, input int c, input int v);
        wr_en = 1'b1; reg_addr = 4'(r); idx = 3'(c); data_in = 16'(v);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wr4(input int r, input int c, input int v);
        wr_en4 = 1'b1; reg_addr4 = 3'(r); idx4 = 2'(c); data_in4 = 8'(v);
        @(posedge clk); #1;
        wr_en4 = 1'b0;
    endtask

    task automatic load8();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                wr8(r, c, a_m[r][c]);
                wr8(8 + r, c, w_m[r][c]);
            end
        end
    endtask

    task automatic calc8(input bit acc_v);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                longint s = 0;
                for (int k = 0; k < 8; k++) s += longint'(a_m[i][k]) * longint'(w_m[j][k]);
                c_m[i][j] = acc_v ? c_m[i][j] + s : s;
            end
        end
    endtask

    task automatic rd8(input int i, input int j, output logic [63:0] v);
        rd_row = 3'(i); rd_col = 3'(j);
        @(posedge clk); #1;
        v = 64'(rd_data);
    endtask

    task automatic check_all8(input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                rd_row = 3'(i); rd_col = 3'(j);
                sb.push_back(64'(c_m[i][j]) & MASK8);
                @(posedge clk); #1;
                check($sformatf("%s_c%0d%0d", tag, i, j), 64'(rd_data), sb.pop_front());
            end
        end
    endtask

    // mode 0 plain, 1 write+start while busy, 2 en low 10 cycles mid-feed, 3 write A[7][7] with start
    task automatic run8(input bit acc_v, input int mode, output int done_edge,
                        output int busy_cnt, output int extra_done);
        start = 1'b1; accum = acc_v;
        if (mode == 3) begin
            wr_en = 1'b1; reg_addr = 4'd7; idx = 3'd7; data_in = 16'(a_m[7][7]);
        end
        @(posedge clk); #1;
        start = 1'b0; accum = 1'b0; wr_en = 1'b0;
        busy_cnt  = int'(busy);
        done_edge = -1;
        for (int k = 1; k <= 100 && done_edge < 0; k++) begin
            if (mode == 1 && k == 5) begin
                wr_en = 1'b1; reg_addr = 4'd0; idx = 3'd0; data_in = 16'd9; start = 1'b1;
            end
            if (mode == 1 && k == 8) begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (mode == 2 && k == 10) en = 1'b0;
            if (mode == 2 && k == 20) en = 1'b1;
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) done_edge = k;
        end
        extra_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          de, bc, ed, cnt;
        logic [63:0] v;

        rst_n = 1'b0;
        en = 1'b1; wr_en = 1'b0; start = 1'b0; accum = 1'b0;
        reg_addr = '0; idx = '0; data_in = '0; rd_row = '0; rd_col = '0;
        en4 = 1'b1; wr_en4 = 1'b0; start4 = 1'b0; accum4 = 1'b0;
        reg_addr4 = '0; idx4 = '0; data_in4 = '0; rd_row4 = '0; rd_col4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        rd8(5, 2, v);
        check("rst_acc_read", v, 64'd0);

        // Test 1: every row {1..8} -> 204 everywhere
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_m[r][c] = c + 1;
                w_m[r][c] = c + 1;
            end
        end
        load8();
        calc8(1'b0);
        run8(1'b0, 0, de, bc, ed);
        check("t1_done_edge", 64'(de), 64'd24);
        check("t1_busy_cycles", 64'(bc), 64'd23);
        check("t1_done_width", 64'(ed), 64'd0);
        check_all8("t1");
        rd8(4, 3, v);
        check("t1_c43_const", v, 64'd204);

        // Test 2: mixed matrices, A[7][7] written on the start edge
        a_m[0] = '{0, 2, 3, 1, 0, 1, 2, 3};
        w_m[0] = '{4, 0, 3, 1, 0, 1, 1, 1};
        for (int r = 1; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_m[r][c] = (r * 3 + c * 5 + 1) % 4;
                w_m[r][c] = (r * 7 + c * 2 + 3) % 5;
            end
        end
        load8();
        a_m[7][7] = 7;
        calc8(1'b0);
        run8(1'b0, 3, de, bc, ed);
        check("t2_done_edge", 64'(de), 64'd24);
        check_all8("t2");
        rd8(0, 0, v);
        check("t2_c00_const", v, 64'd16);

        // Test 3: accumulate in place, then fresh run
        calc8(1'b1);
        run8(1'b1, 0, de, bc, ed);
        check("t3_done_edge", 64'(de), 64'd24);
        check_all8("t3acc");
        rd8(0, 0, v);
        check("t3_c00_const", v, 64'd32);
        calc8(1'b0);
        run8(1'b0, 0, de, bc, ed);
        rd8(0, 0, v);
        check("t3_c00_fresh", v, 64'd16);
        check_all8("t3fresh");

        // Test 4: write and start while busy are ignored
        run8(1'b0, 1, de, bc, ed);
        check("t4_done_edge", 64'(de), 64'd24);
        check("t4_extra_done", 64'(ed), 64'd0);
        check_all8("t4");

        // Test 5: clock enable stall mid-feed
        run8(1'b0, 2, de, bc, ed);
        check("t5_done_edge", 64'(de), 64'd34);
        check_all8("t5");

        // Reset mid-feed aborts the run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_rd_data", 64'(rd_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("t5_no_done_after_rst", 64'(cnt), 64'd0);
        rd8(7, 7, v);
        check("t5_acc_cleared", v, 64'd0);

        // Test 6: 4x4 signed, A = -I, W^T row j filled with j+1
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                wr4(r, c, (r == c) ? -1 : 0);
                wr4(4 + r, c, r + 1);
            end
        end
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        de = -1;
        for (int k = 1; k <= 60 && de < 0; k++) begin
            @(posedge clk); #1;
            if (done4) de = k;
        end
        check("t6_done_edge", 64'(de), 64'd12);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                rd_row4 = 2'(i); rd_col4 = 2'(j);
                sb.push_back(64'(-(j + 1)) & MASK4);
                @(posedge clk); #1;
                check($sformatf("t6_c%0d%0d", i, j), 64'(rd_data4), sb.pop_front());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
